pulse_stretcher: RTL

- Expands single-cycle trigger pulses into a clean high level of programmable length. This is the inverse of the level-to-pulse one-shot.
- Used in the frequency counter to build gate windows and visible indicator pulses from single-cycle edge events.
- Has one clock domain, a run-time length input, an end-of-window strobe, and a sticky missed-trigger flag.

---
 rtl/freq_pkg.sv | 15 +
 rtl/pulse_stretcher_down_counter.sv | 33 +++
 rtl/pulse_stretcher.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-counter blocks: clock constants,
// the default counter width and the pulse-stretcher state encoding.
package freq_pkg;

    localparam int CLK_HZ    = 50_000_000;
    localparam int GATE_1S   = CLK_HZ;
    localparam int CNT_W_DEF = 26;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_HOLDOFF = 2'd2
    } ps_state_e;

endpackage

// File: rtl/pulse_stretcher_down_counter.sv
// Loadable down-counter with enable and zero flag. Load wins over the
// decrement, and the count sticks at zero rather than wrapping.
module down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Count register: reload on load, otherwise decrement while enabled and non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle trigger events into a high level of
// run-time programmable length, followed by an optional holdoff period.
// Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN -- when defined, a
// trigger during the window restarts it from the current len instead of
// being flagged as missed.
module pulse_stretcher
    import freq_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int HOLDOFF = 0,
    parameter int HO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic [CNT_W-1:0] len,
    input  logic             clr_missed,
    output logic             out_level,
    output logic             busy,
    output logic             done,
    output logic             missed
);

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               HAS_HO  = (HOLDOFF > 0);
    localparam logic [HO_W-1:0]  HO_LOAD = HAS_HO ? HO_W'(HOLDOFF - 1) : {HO_W{1'b0}};

    ps_state_e        state_r;
    ps_state_e        state_s;
    logic             out_level_r;
    logic             busy_r;
    logic             done_r;
    logic             missed_r;

    logic             win_load_s;
    logic             win_en_s;
    logic             win_zero_s;
    logic [CNT_W-1:0] win_val_s;
    logic             ho_load_s;
    logic             ho_en_s;
    logic             ho_zero_s;
    logic             done_s;
    logic             miss_set_s;

    // A zero length is treated as one cycle; the counter holds (length - 1).
    assign win_val_s = (len == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (len - ONE);

    down_counter #(.W(CNT_W)) u_win_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load_s),
        .en       (win_en_s),
        .load_val (win_val_s),
        .zero     (win_zero_s)
    );

    generate
        if (HOLDOFF > 0) begin : g_ho
            down_counter #(.W(HO_W)) u_ho_cnt (
                .clk      (clk),
                .rst      (rst),
                .load     (ho_load_s),
                .en       (ho_en_s),
                .load_val (HO_LOAD),
                .zero     (ho_zero_s)
            );
        end else begin : g_no_ho
            logic unused_ho_s;
            assign unused_ho_s = ho_load_s | ho_en_s;
            assign ho_zero_s   = 1'b1;
        end
    endgenerate

    // Next-state, counter control, done strobe and missed-trigger detection.
    always_comb begin
        state_s    = state_r;
        win_load_s = 1'b0;
        win_en_s   = 1'b0;
        ho_load_s  = 1'b0;
        ho_en_s    = 1'b0;
        done_s     = 1'b0;
        miss_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_in) begin
                    win_load_s = 1'b1;
                    state_s    = ST_STRETCH;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_STRETCH: begin
                win_en_s = 1'b1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                if (trig_in) begin
                    win_load_s = 1'b1;
                    state_s    = ST_STRETCH;
                end else if (win_zero_s) begin
`else
                miss_set_s = trig_in;
                if (win_zero_s) begin
`endif
                    done_s = 1'b1;
                    if (HAS_HO) begin
                        ho_load_s = 1'b1;
                        state_s   = ST_HOLDOFF;
                    end else begin
                        state_s   = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STRETCH;
                end
            end
            ST_HOLDOFF: begin
                ho_en_s    = 1'b1;
                miss_set_s = trig_in;
                if (ho_zero_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLDOFF;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            out_level_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            missed_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_level_r <= (state_s == ST_STRETCH);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= done_s;
            if (miss_set_s) begin
                missed_r <= 1'b1;
            end else if (clr_missed) begin
                missed_r <= 1'b0;
            end else begin
                missed_r <= missed_r;
            end
        end
    end

    assign out_level = out_level_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign missed    = missed_r;

endmodule
